// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and the
// default end-of-program marker.
package instr_loader_pkg;

  // CHECK is only entered when the checksum feature is built in.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRecv  = 3'd1,
    StWrite = 3'd2,
    StCheck = 3'd3,
    StDone  = 3'd4
  } loader_state_e;

  localparam logic [31:0] HaltWordDefault = 32'hFFFF_FFFF;

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// Byte-to-word assembler for the instruction loader.
// Collects four accepted bytes big-endian (first byte ends up in the MSBs) and
// flags the cycle in which the fourth byte is accepted.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   clear_i      restart assembly (byte index and word cleared)
//   accept_i     a byte is transferred this cycle
//   byte_i       the transferred byte
//   word_o       assembled word (shift register contents)
//   word_valid_o fourth byte of a word is being accepted this cycle
module instr_loader_byte_assembler #(
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 accept_i,
  input  logic [ByteWidth-1:0] byte_i,
  output logic [DataWidth-1:0] word_o,
  output logic                 word_valid_o
);

  logic [1:0]           idx_q, idx_d;
  logic [DataWidth-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (accept_i) begin
      // Index wraps 3 -> 0 so the next word starts cleanly.
      idx_d  = idx_q + 2'd1;
      word_d = {word_q[DataWidth-ByteWidth-1:0], byte_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = accept_i && !clear_i && (idx_q == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Instruction-memory loader: turns a valid/ready byte stream into 32-bit
// writes at byte addresses 0, 4, 8, ... until the halt word has been written.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running XOR of all
// accepted bytes and a trailing checksum byte checked in the CHECK state.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_start            begin a load (honoured in IDLE or DONE only)
//   i_rx_data/valid    incoming byte stream; o_rx_ready is the accept side
//   o_imem_we/addr/wdata  instruction-memory write port
//   o_busy             load in progress
//   o_done             load finished (sticky until next start)
//   o_overflow         program exceeded MaxWords (sticky)
//   o_chk_err          checksum mismatch (sticky; 0 without the feature)
//   o_word_count       words written during this load
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned          ByteWidth = 8,
  parameter int unsigned          DataWidth = 32,
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          MaxWords  = 256,
  parameter logic [DataWidth-1:0] HaltWord  = HaltWordDefault
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [ByteWidth-1:0] i_rx_data,
  input  logic                 i_rx_valid,
  output logic                 o_rx_ready,
  output logic                 o_imem_we,
  output logic [AddrWidth-1:0] o_imem_addr,
  output logic [DataWidth-1:0] o_imem_wdata,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow,
  output logic                 o_chk_err,
  output logic [AddrWidth-1:0] o_word_count
);

  loader_state_e state_q, state_d;

  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [AddrWidth-1:0] addr_plus_four;

  logic accept;
  logic start_ok;
  logic asm_accept;
  logic word_done;
  logic full;
  logic is_halt;

  assign accept     = i_rx_valid && o_rx_ready;
  assign start_ok   = i_start && ((state_q == StIdle) || (state_q == StDone));
  assign asm_accept = accept && (state_q == StRecv);
  assign full       = (count_q == AddrWidth'(MaxWords));
  assign is_halt    = (o_imem_wdata == HaltWord);

  // adder_four: next word address, wraps modulo 2^AddrWidth.
  assign addr_plus_four = addr_q + AddrWidth'(4);

  instr_loader_byte_assembler #(
    .ByteWidth(ByteWidth),
    .DataWidth(DataWidth)
  ) u_byte_assembler (
    .clk_i       (i_clk),
    .rst_i       (i_reset),
    .clear_i     (start_ok),
    .accept_i    (asm_accept),
    .byte_i      (i_rx_data),
    .word_o      (o_imem_wdata),
    .word_valid_o(word_done)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) state_d = StRecv;
      end
      StRecv: begin
        // A completed word that does not fit is dropped and ends the load.
        if (word_done) state_d = full ? StDone : StWrite;
      end
      StWrite: begin
        if (is_halt) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StRecv;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) state_d = StDone;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    o_rx_ready = 1'b0;
    o_imem_we  = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    unique case (state_q)
      StRecv: begin
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
      end
      StWrite: begin
        o_imem_we = 1'b1;
        o_busy    = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      StCheck: begin
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
      end
`endif
      StDone:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Address, word count and overflow flag
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (start_ok) begin
      addr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (state_q == StWrite) begin
      addr_d  = addr_plus_four;
      count_d = count_q + AddrWidth'(1);
    end else if ((state_q == StRecv) && word_done && full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      addr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_imem_addr  = addr_q;
  assign o_word_count = count_q;
  assign o_overflow   = ovf_q;

`ifdef LOADER_CHECKSUM_EN
  logic [ByteWidth-1:0] xor_q, xor_d;
  logic                 chk_err_q, chk_err_d;

  always_comb begin
    xor_d     = xor_q;
    chk_err_d = chk_err_q;
    if (start_ok) begin
      xor_d     = '0;
      chk_err_d = 1'b0;
    end else if (asm_accept) begin
      xor_d = xor_q ^ i_rx_data;
    end else if ((state_q == StCheck) && accept) begin
      chk_err_d = (i_rx_data != xor_q);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      xor_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      xor_q     <= xor_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign o_chk_err = chk_err_q;
`else
  assign o_chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader (MaxWords reduced to 4 so overflow is
// reachable). Directed loads plus randomized programs against a word-level
// reference model. Build with +define+LOADER_CHECKSUM_EN to cover the checksum.
module tb_instr_loader;

  localparam int unsigned MaxW = 4;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        chk_err;
  logic [31:0] word_count;

  instr_loader #(
    .MaxWords(MaxW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .o_rx_ready  (rx_ready),
    .o_imem_we   (imem_we),
    .o_imem_addr (imem_addr),
    .o_imem_wdata(imem_wdata),
    .o_busy      (busy),
    .o_done      (done),
    .o_overflow  (ovf),
    .o_chk_err   (chk_err),
    .o_word_count(word_count)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observed memory writes
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  // Reference model results
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_ovf;
  bit          exp_halted;
  int          exp_used;
  logic [7:0]  exp_xor;

  // Word-level view: word k goes to 4*k unless k reaches capacity; halt ends it.
  task automatic model(input byte_q_t prog);
    logic [31:0] w;
    int          k;
    exp_addr.delete();
    exp_data.delete();
    exp_ovf    = 0;
    exp_halted = 0;
    exp_used   = 0;
    exp_xor    = 8'h00;
    k          = 0;
    while (exp_used + 4 <= prog.size()) begin
      w = {prog[exp_used], prog[exp_used+1], prog[exp_used+2], prog[exp_used+3]};
      for (int j = 0; j < 4; j++) exp_xor = exp_xor ^ prog[exp_used+j];
      exp_used += 4;
      if (k == MaxW) begin
        exp_ovf = 1;
        break;
      end
      exp_addr.push_back(32'(4 * k));
      exp_data.push_back(w);
      k++;
      if (w == 32'hFFFF_FFFF) begin
        exp_halted = 1;
        break;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard;
    guard = 0;
    if (gap) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready) check_eq("ready_timeout", {63'd0, rx_ready}, 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_and_check(input string name, input byte_q_t prog, input bit gap,
                               input bit bad_chk, input bit mid_start);
    logic [7:0] cb;
    bit         exp_chk;
    int         guard;
    model(prog);
    wr_addr.delete();
    wr_data.delete();
    exp_chk = 0;
    pulse_start();
    for (int i = 0; i < exp_used; i++) begin
      if (mid_start && i == 2) pulse_start();
      send_byte(prog[i], gap);
      if (i == 3) begin
        check_eq({name, "_lat_we"}, {63'd0, imem_we}, 64'd1);
        check_eq({name, "_lat_rdy"}, {63'd0, rx_ready}, 64'd0);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (exp_halted) begin
      cb = bad_chk ? (exp_xor ^ 8'($urandom_range(1, 255))) : exp_xor;
      exp_chk = bad_chk;
      send_byte(cb, gap);
    end
`else
    cb = 8'h00;
    if (bad_chk) exp_chk = 0;
`endif
    guard = 0;
    while (!done && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq({name, "_done"}, {63'd0, done}, 64'd1);
    check_eq({name, "_busy"}, {63'd0, busy}, 64'd0);
    check_eq({name, "_ovf"}, {63'd0, ovf}, {63'd0, exp_ovf});
    check_eq({name, "_chk"}, {63'd0, chk_err}, {63'd0, exp_chk});
    check_eq({name, "_count"}, {32'd0, word_count}, 64'(exp_addr.size()));
    check_eq({name, "_nwr"}, 64'(wr_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < wr_addr.size()) begin
        check_eq($sformatf("%s_addr%0d", name, i), {32'd0, wr_addr[i]}, {32'd0, exp_addr[i]});
        check_eq($sformatf("%s_data%0d", name, i), {32'd0, wr_data[i]}, {32'd0, exp_data[i]});
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  byte_q_t p1;
  byte_q_t p3;
  byte_q_t pr;
  int      nw;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    p1 = '{8'h24, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    p3 = {};
    for (int i = 0; i < 5; i++) p3 = {p3, 8'h10, 8'h00, 8'h00, 8'(i + 1)};
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_ready", {63'd0, rx_ready}, 64'd0);
    check_eq("rst_we", {63'd0, imem_we}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_ovf", {63'd0, ovf}, 64'd0);
    check_eq("rst_chk", {63'd0, chk_err}, 64'd0);
    check_eq("rst_addr", {32'd0, imem_addr}, 64'd0);
    check_eq("rst_count", {32'd0, word_count}, 64'd0);
    check_eq("rst_wdata", {32'd0, imem_wdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic two-word program
    run_and_check("t1", p1, 0, 0, 0);
    if (wr_data.size() == 2) begin
      check_eq("t1_word0", {32'd0, wr_data[0]}, 64'h2408_0005);
      check_eq("t1_word1", {32'd0, wr_data[1]}, 64'hFFFF_FFFF);
      check_eq("t1_addr1", {32'd0, wr_addr[1]}, 64'd4);
    end else begin
      check_eq("t1_nwrites", 64'(wr_data.size()), 64'd2);
    end

    // 2: valid toggling every cycle
    run_and_check("t2", p1, 1, 0, 0);

    // 3: five non-halt words into a four-word memory
    run_and_check("t3", p3, 0, 0, 0);
    check_eq("t3_ovf_direct", {63'd0, ovf}, 64'd1);

    // 5b: restart from DONE after overflow clears flags and address
    pulse_start();
    check_eq("t5_done_clr", {63'd0, done}, 64'd0);
    check_eq("t5_ovf_clr", {63'd0, ovf}, 64'd0);
    check_eq("t5_addr_clr", {32'd0, imem_addr}, 64'd0);
    check_eq("t5_count_clr", {32'd0, word_count}, 64'd0);
    check_eq("t5_busy", {63'd0, busy}, 64'd1);
    // 5a: start while receiving is ignored (loader already in RECV here too)
    run_and_check("t5", p1, 0, 0, 1);

    // 4: reset after two words plus two bytes
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i), 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t4_nwr_before", 64'(wr_addr.size()), 64'd2);
    check_eq("t4_busy", {63'd0, busy}, 64'd0);
    check_eq("t4_ready", {63'd0, rx_ready}, 64'd0);
    check_eq("t4_addr", {32'd0, imem_addr}, 64'd0);
    check_eq("t4_count", {32'd0, word_count}, 64'd0);
    check_eq("t4_wdata", {32'd0, imem_wdata}, 64'd0);
    rst      = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (8) @(negedge clk);
    rx_valid = 1'b0;
    check_eq("t4_nwr_after", 64'(wr_addr.size()), 64'd2);
    check_eq("t4_idle_done", {63'd0, done}, 64'd0);
    run_and_check("t4_reload", p1, 0, 0, 0);

    // 6: checksum good then bad (chk stays 0 without the feature)
    run_and_check("t6_good", p1, 0, 0, 0);
    run_and_check("t6_bad", p1, 0, 1, 0);

    // Randomized programs
    for (int r = 0; r < 12; r++) begin
      pr = {};
      nw = $urandom_range(0, 5);
      for (int w = 0; w < nw; w++) begin
        for (int j = 0; j < 4; j++) pr.push_back(8'($urandom_range(0, 254)));
      end
      for (int j = 0; j < 4; j++) pr.push_back(8'hFF);
      run_and_check($sformatf("rnd%0d", r), pr, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
